// File: rtl/crc_attach_ctrl.sv
// Sequencer for serial CRC-16 attachment: streams the payload through to the output while the
// engine absorbs it, then appends the engine's parity bits with first/last framing.
module crc_attach_ctrl #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CRC_LEN = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] tb_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             crc_init,
  output logic             crc_active,
  output logic             crc_data,
  input  logic             crc_par,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned     ParW    = (CRC_LEN > 1) ? $clog2(CRC_LEN) : 1;
  localparam logic [ParW-1:0] ParLast = ParW'(CRC_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ParW-1:0]  par_cnt_q, par_cnt_d;
  logic             init_q, init_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_last;

  // Compare against len-1 so a maximum-length block never needs the counter to wrap.
  assign len_last = len_q - 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      par_cnt_q   <= '0;
      init_q      <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      par_cnt_q   <= par_cnt_d;
      init_q      <= init_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    par_cnt_d   = par_cnt_q;
    init_d      = 1'b0;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (tb_len != '0) begin
            len_d     = tb_len;
            cnt_d     = '0;
            par_cnt_d = '0;
            init_d    = 1'b1;
            state_d   = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          out_bit_d   = in_bit;
          out_valid_d = 1'b1;
          out_first_d = (cnt_q == '0);
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == len_last) begin
            state_d = StFlush;
          end
        end else begin
          // The engine cannot stall, so a gap in the payload aborts the block.
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StFlush: begin
        out_bit_d   = crc_par;
        out_valid_d = 1'b1;
        out_last_d  = (par_cnt_q == ParLast);
        par_cnt_d   = par_cnt_q + 1'b1;
        if (par_cnt_q == ParLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StLoad);
    crc_active = in_ready & in_valid;
    crc_data   = in_ready & in_bit;
    crc_init   = init_q;
    busy       = (state_q != StIdle);
    out_bit    = out_bit_q;
    out_valid  = out_valid_q;
    out_first  = out_first_q;
    out_last   = out_last_q;
    done       = done_q;
    err        = err_q;
  end

endmodule
